// File: rtl/regwrite_port_arbiter.sv
// Three-requester round-robin arbiter driving one shared register write port.
// A grant is registered: ack/we_out/waddr_out/wdata_out appear the cycle after the sampling edge.
module regwrite_port_arbiter #(
  parameter int W  = 32,
  parameter int AW = 4
) (
  input  logic          clk,
  input  logic          reset_synchronous_n,
  input  logic          stall,
  input  logic [2:0]    req,
  input  logic [AW-1:0] addr0,
  input  logic [AW-1:0] addr1,
  input  logic [AW-1:0] addr2,
  input  logic [W-1:0]  data0,
  input  logic [W-1:0]  data1,
  input  logic [W-1:0]  data2,
  output logic [2:0]    ack,
  output logic          we_out,
  output logic [AW-1:0] waddr_out,
  output logic [W-1:0]  wdata_out,
  output logic [1:0]    grant_id
);

  logic [1:0]    r_rr_ptr;
  logic [2:0]    r_ack;
  logic          r_we;
  logic [AW-1:0] r_waddr;
  logic [W-1:0]  r_wdata;
  logic [1:0]    r_grant_id;

  logic [2:0]    w_elig;
  logic          w_hit;
  logic [1:0]    w_sel;
  logic [1:0]    w_next_ptr;
  logic [2:0]    w_onehot;
  logic [AW-1:0] w_addr_sel;
  logic [W-1:0]  w_data_sel;

  // A requester acked this cycle is still showing its old item; exclude it.
  assign w_elig = req & ~r_ack;

  always_comb begin
    w_hit = 1'b0;
    w_sel = 2'd0;
    case (r_rr_ptr)
      2'd1: begin
        if (w_elig[1])      begin w_hit = 1'b1; w_sel = 2'd1; end
        else if (w_elig[2]) begin w_hit = 1'b1; w_sel = 2'd2; end
        else if (w_elig[0]) begin w_hit = 1'b1; w_sel = 2'd0; end
      end
      2'd2: begin
        if (w_elig[2])      begin w_hit = 1'b1; w_sel = 2'd2; end
        else if (w_elig[0]) begin w_hit = 1'b1; w_sel = 2'd0; end
        else if (w_elig[1]) begin w_hit = 1'b1; w_sel = 2'd1; end
      end
      default: begin
        if (w_elig[0])      begin w_hit = 1'b1; w_sel = 2'd0; end
        else if (w_elig[1]) begin w_hit = 1'b1; w_sel = 2'd1; end
        else if (w_elig[2]) begin w_hit = 1'b1; w_sel = 2'd2; end
      end
    endcase
  end

  always_comb begin
    w_addr_sel = addr0;
    w_data_sel = data0;
    w_onehot   = 3'b001;
    w_next_ptr = 2'd1;
    case (w_sel)
      2'd1: begin
        w_addr_sel = addr1;
        w_data_sel = data1;
        w_onehot   = 3'b010;
        w_next_ptr = 2'd2;
      end
      2'd2: begin
        w_addr_sel = addr2;
        w_data_sel = data2;
        w_onehot   = 3'b100;
        w_next_ptr = 2'd0;
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!reset_synchronous_n) begin
      r_rr_ptr   <= 2'd0;
      r_ack      <= 3'b000;
      r_we       <= 1'b0;
      r_waddr    <= '0;
      r_wdata    <= '0;
      r_grant_id <= 2'd0;
    end else if (!stall && w_hit) begin
      r_rr_ptr   <= w_next_ptr;
      r_ack      <= w_onehot;
      r_we       <= 1'b1;
      r_waddr    <= w_addr_sel;
      r_wdata    <= w_data_sel;
      r_grant_id <= w_sel;
    end else begin
      // Idle or stalled: pulses drop, everything else holds.
      r_ack <= 3'b000;
      r_we  <= 1'b0;
    end
  end

  assign ack       = r_ack;
  assign we_out    = r_we;
  assign waddr_out = r_waddr;
  assign wdata_out = r_wdata;
  assign grant_id  = r_grant_id;

endmodule

// File: tb/tb_regwrite_port_arbiter.sv
// Directed bench for regwrite_port_arbiter: per-scenario tasks with hand-computed expectations.
module tb_regwrite_port_arbiter;
  localparam int W  = 32;
  localparam int AW = 4;

  logic          clk = 1'b0;
  logic          rst_n;
  logic          stall;
  logic [2:0]    req;
  logic [AW-1:0] addr0, addr1, addr2;
  logic [W-1:0]  data0, data1, data2;
  logic [2:0]    ack;
  logic          we_out;
  logic [AW-1:0] waddr_out;
  logic [W-1:0]  wdata_out;
  logic [1:0]    grant_id;

  int n_cmp = 0;
  int n_bad = 0;

  regwrite_port_arbiter #(.W(W), .AW(AW)) dut (
    .clk(clk), .reset_synchronous_n(rst_n), .stall(stall), .req(req),
    .addr0(addr0), .addr1(addr1), .addr2(addr2),
    .data0(data0), .data1(data1), .data2(data2),
    .ack(ack), .we_out(we_out), .waddr_out(waddr_out),
    .wdata_out(wdata_out), .grant_id(grant_id)
  );

  always #5 clk = ~clk;

  // Outputs packed as {we, ack, gid, waddr, wdata} for one-shot comparisons.
  logic [1+3+2+AW+W-1:0] obs;
  assign obs = {we_out, ack, grant_id, waddr_out, wdata_out};

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst_n = 1'b0; stall = 1'b0; req = 3'b000;
    step();
    rst_n = 1'b1;
  endtask

  task automatic test_reset();
    rst_n = 1'b0; stall = 1'b0; req = 3'b111;
    step();
    n_cmp++;
    if (obs !== '0) begin
      n_bad++;
      $display("FAIL reset_outputs: got %h want 0", obs);
    end
    stall = 1'b1;
    step();
    n_cmp++;
    if (obs !== '0) begin
      n_bad++;
      $display("FAIL reset_overrides_stall: got %h want 0", obs);
    end
    stall = 1'b0; rst_n = 1'b1; req = 3'b000;
  endtask

  task automatic test_single();
    do_reset();
    req = 3'b010; addr1 = 4'd5; data1 = 32'hDEADBEEF;
    step();
    n_cmp++;
    if (obs !== {1'b1, 3'b010, 2'd1, 4'd5, 32'hDEADBEEF}) begin
      n_bad++;
      $display("FAIL single_grant1: got %h want %h", obs, {1'b1, 3'b010, 2'd1, 4'd5, 32'hDEADBEEF});
    end
    req = 3'b000;
    step();
    n_cmp++;
    if (obs !== {1'b0, 3'b000, 2'd1, 4'd5, 32'hDEADBEEF}) begin
      n_bad++;
      $display("FAIL single_idle_hold: got %h want %h", obs, {1'b0, 3'b000, 2'd1, 4'd5, 32'hDEADBEEF});
    end
  endtask

  task automatic test_rotation();
    logic [1:0] exp_ids [4];
    int got;
    exp_ids[0] = 2'd0; exp_ids[1] = 2'd1; exp_ids[2] = 2'd2; exp_ids[3] = 2'd0;
    do_reset();
    addr0 = 4'd1; addr1 = 4'd2; addr2 = 4'd3;
    req = 3'b111;
    got = 0;
    for (int cyc = 0; cyc < 16 && got < 4; cyc++) begin
      step();
      if (we_out) begin
        n_cmp++;
        if (grant_id !== exp_ids[got] || ack !== (3'b001 << exp_ids[got])) begin
          n_bad++;
          $display("FAIL rotation_grant%0d: got id=%0d ack=%b want id=%0d ack=%b",
                   got, grant_id, ack, exp_ids[got], 3'b001 << exp_ids[got]);
        end
        got++;
      end else begin
        n_cmp++;
        if (ack !== 3'b000) begin
          n_bad++;
          $display("FAIL rotation_ack_without_we: got ack=%b want 000", ack);
        end
      end
    end
    n_cmp++;
    if (got != 4) begin
      n_bad++;
      $display("FAIL rotation_timeout: got %0d grants want 4", got);
    end
    req = 3'b000;
    step();
  endtask

  task automatic test_wrap();
    do_reset();
    data0 = 32'h0000_0A0A; data2 = 32'h0000_0C0C; addr0 = 4'd7; addr2 = 4'd9;
    req = 3'b001;
    step();
    req = 3'b000;
    step();
    req = 3'b101;
    step();
    n_cmp++;
    if (obs !== {1'b1, 3'b100, 2'd2, 4'd9, 32'h0000_0C0C}) begin
      n_bad++;
      $display("FAIL wrap_grant2_first: got %h want %h", obs, {1'b1, 3'b100, 2'd2, 4'd9, 32'h0000_0C0C});
    end
    step();
    n_cmp++;
    if (obs !== {1'b1, 3'b001, 2'd0, 4'd7, 32'h0000_0A0A}) begin
      n_bad++;
      $display("FAIL wrap_grant0_next: got %h want %h", obs, {1'b1, 3'b001, 2'd0, 4'd7, 32'h0000_0A0A});
    end
    req = 3'b000;
    step();
  endtask

  // Entered with rr_ptr=1, grant_id=0, waddr=7, wdata=0x0A0A left by test_wrap.
  task automatic test_stall();
    stall = 1'b1; req = 3'b111;
    for (int i = 0; i < 3; i++) begin
      step();
      n_cmp++;
      if (obs !== {1'b0, 3'b000, 2'd0, 4'd7, 32'h0000_0A0A}) begin
        n_bad++;
        $display("FAIL stall_hold%0d: got %h want %h", i, obs, {1'b0, 3'b000, 2'd0, 4'd7, 32'h0000_0A0A});
      end
    end
    stall = 1'b0;
    step();
    n_cmp++;
    if (we_out !== 1'b1 || ack !== 3'b010 || grant_id !== 2'd1) begin
      n_bad++;
      $display("FAIL stall_release: got we=%b ack=%b id=%0d want we=1 ack=010 id=1", we_out, ack, grant_id);
    end
    req = 3'b000;
    step();
  endtask

  task automatic test_reset_mid();
    do_reset();
    addr1 = 4'd5; data1 = 32'h1111_2222; addr2 = 4'd9; data2 = 32'h3333_4444;
    req = 3'b010;
    step();
    req = 3'b100; rst_n = 1'b0;
    step();
    n_cmp++;
    if (obs !== '0) begin
      n_bad++;
      $display("FAIL reset_mid_drop: got %h want 0", obs);
    end
    rst_n = 1'b1; req = 3'b111; addr0 = 4'd4; data0 = 32'h5555_6666;
    step();
    n_cmp++;
    if (obs !== {1'b1, 3'b001, 2'd0, 4'd4, 32'h5555_6666}) begin
      n_bad++;
      $display("FAIL reset_mid_first_grant: got %h want %h", obs, {1'b1, 3'b001, 2'd0, 4'd4, 32'h5555_6666});
    end
    req = 3'b000;
    step();
  endtask

  // Requester 0 holds req through its ack; address 0 must pass through untouched.
  task automatic test_back_to_back();
    logic [2:0] exp_ack [4];
    exp_ack[0] = 3'b001; exp_ack[1] = 3'b000; exp_ack[2] = 3'b001; exp_ack[3] = 3'b000;
    do_reset();
    addr0 = 4'd0; data0 = 32'h1234_5678;
    req = 3'b001;
    for (int i = 0; i < 4; i++) begin
      step();
      n_cmp++;
      if (ack !== exp_ack[i] || we_out !== exp_ack[i][0]) begin
        n_bad++;
        $display("FAIL hold_ack_cycle%0d: got ack=%b we=%b want ack=%b", i, ack, we_out, exp_ack[i]);
      end
    end
    n_cmp++;
    if (waddr_out !== 4'd0 || wdata_out !== 32'h1234_5678) begin
      n_bad++;
      $display("FAIL addr0_write: got addr=%0d data=%h want 0 12345678", waddr_out, wdata_out);
    end
    req = 3'b000;
    step();
  endtask

  task automatic test_withdraw();
    do_reset();
    stall = 1'b1; req = 3'b010;
    step();
    stall = 1'b0; req = 3'b000;
    step();
    n_cmp++;
    if (we_out !== 1'b0 || ack !== 3'b000) begin
      n_bad++;
      $display("FAIL withdraw_no_write: got we=%b ack=%b want 0 000", we_out, ack);
    end
  endtask

  initial begin
    rst_n = 1'b0; stall = 1'b0; req = 3'b000;
    addr0 = '0; addr1 = '0; addr2 = '0;
    data0 = '0; data1 = '0; data2 = '0;
    test_reset();
    test_single();
    test_rotation();
    test_wrap();
    test_stall();
    test_reset_mid();
    test_back_to_back();
    test_withdraw();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
